// File: rtl/serial_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter.
//   state_e    : FSM state encoding (fixed 2-bit)
//   PW_DEF     : default maximum pattern width
//   RW_DEF     : default repeat-count width
//   clamp_len  : maps a requested length of 0 or >pw to pw
package serial_pattern_tx_pkg;

    localparam int PW_DEF = 8;
    localparam int RW_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        PAR   = 2'b10,
        DONE  = 2'b11
    } state_e;

    function automatic int clamp_len(input int len, input int pw);
        return ((len == 0) || (len > pw)) ? pw : len;
    endfunction

endpackage

// File: rtl/serial_pattern_tx_shreg.sv
// Loadable MSB-first shift register. A load places pat_i[len_i-1] at the MSB,
// so the bit on msb_o is always the one currently being transmitted.
//   clk, rst  : clock, synchronous active-high reset (clears the register)
//   clr_i     : clear to zero (highest priority)
//   load_i    : len-aligned load of pat_i
//   shift_i   : shift left by one, zero fill
//   pat_i     : value to load
//   len_i     : number of meaningful low bits in pat_i (1..PW)
//   msb_o     : current MSB
module serial_pattern_tx_shreg
    import serial_pattern_tx_pkg::*;
#(
    parameter int PW = PW_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  load_i,
    input  logic                  shift_i,
    input  logic [PW-1:0]         pat_i,
    input  logic [$clog2(PW):0]   len_i,
    output logic                  msb_o
);

    logic [PW-1:0] sh_q, sh_d;

    always_comb begin
        sh_d = sh_q;
        if (clr_i) begin
            sh_d = '0;
        end else if (load_i) begin
            // Align so that bit len-1 lands in the MSB; bits below the
            // frame are zero and never reach the output.
            sh_d = pat_i << (PW - int'(len_i));
        end else if (shift_i) begin
            sh_d = {sh_q[PW-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign msb_o = sh_q[PW-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter. Captures pat/len/rep on start&ready and sends
// (rep+1) frames of len bits, MSB-first, one bit per clock.
// Optional feature macro: SERIAL_PATTERN_TX_PARITY_EN appends one even-parity
// cycle after every frame (ports are identical in both builds).
//   clk, rst   : clock, synchronous active-high reset
//   start      : transfer request, sampled only while ready=1
//   pat        : pattern; pat[len-1] is sent first
//   len        : bits per frame; 0 or >PW means PW
//   rep        : extra repetitions (frames = rep+1)
//   ready      : high only in IDLE
//   out        : serial data, 0 whenever out_valid=0
//   out_valid  : high on every stream-bit cycle
//   done       : one-cycle pulse after the final bit
//
// state | meaning
// IDLE  | waiting for start, ready=1
// SHIFT | sending frame bits
// PAR   | sending the frame's parity bit (parity build only)
// DONE  | done pulse, then back to IDLE
module serial_pattern_tx
    import serial_pattern_tx_pkg::*;
#(
    parameter int PW = PW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [PW-1:0]         pat,
    input  logic [$clog2(PW):0]   len,
    input  logic [RW-1:0]         rep,
    output logic                  ready,
    output logic                  out,
    output logic                  out_valid,
    output logic                  done
);

    localparam int LW = $clog2(PW) + 1;

    state_e          state_q, state_d;
    logic [PW-1:0]   pat_q, pat_d;
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   bit_q, bit_d;
    logic [RW-1:0]   frame_q, frame_d;
    logic            out_valid_q, out_valid_d;
    logic            done_q, done_d;
    logic            ready_q, ready_d;

    logic            sh_clr, sh_load, sh_shift;
    logic [PW-1:0]   ld_pat;
    logic [LW-1:0]   ld_len;
    logic [LW-1:0]   len_c;
    logic            frame_end;

    assign len_c = LW'(clamp_len(int'(len), PW));

`ifdef SERIAL_PATTERN_TX_PARITY_EN
    logic par;
    // Mask off bits above the frame; with len=PW the shift wraps to 0 and
    // the subtraction yields all ones, which is the desired mask.
    assign par = ^(pat_q & ((PW'(1) << len_q) - PW'(1)));
`endif

    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        len_d       = len_q;
        bit_d       = bit_q;
        frame_d     = frame_q;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        ready_d     = 1'b0;
        sh_clr      = 1'b0;
        sh_load     = 1'b0;
        sh_shift    = 1'b0;
        ld_pat      = pat_q;
        ld_len      = len_q;
        frame_end   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pat_d       = pat;
                    len_d       = len_c;
                    frame_d     = rep;
                    bit_d       = len_c - LW'(1);
                    ld_pat      = pat;
                    ld_len      = len_c;
                    sh_load     = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = SHIFT;
                end else begin
                    ready_d = 1'b1;
                end
            end
            SHIFT: begin
                if (bit_q != '0) begin
                    bit_d       = bit_q - LW'(1);
                    sh_shift    = 1'b1;
                    out_valid_d = 1'b1;
                end else begin
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                    // Parity goes out through the shift register as a 1-bit frame.
                    ld_pat      = {{(PW-1){1'b0}}, par};
                    ld_len      = LW'(1);
                    sh_load     = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = PAR;
`else
                    frame_end   = 1'b1;
`endif
                end
            end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            PAR: begin
                frame_end = 1'b1;
            end
`endif
            DONE: begin
                ready_d = 1'b1;
                sh_clr  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                ready_d = 1'b1;
                sh_clr  = 1'b1;
                state_d = IDLE;
            end
        endcase

        if (frame_end) begin
            if (frame_q != '0) begin
                frame_d     = frame_q - RW'(1);
                bit_d       = len_q - LW'(1);
                sh_load     = 1'b1;
                out_valid_d = 1'b1;
                state_d     = SHIFT;
            end else begin
                sh_clr  = 1'b1;
                done_d  = 1'b1;
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pat_q       <= '0;
            len_q       <= '0;
            bit_q       <= '0;
            frame_q     <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            len_q       <= len_d;
            bit_q       <= bit_d;
            frame_q     <= frame_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            ready_q     <= ready_d;
        end
    end

    serial_pattern_tx_shreg #(.PW(PW)) u_shreg (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (sh_clr),
        .load_i  (sh_load),
        .shift_i (sh_shift),
        .pat_i   (ld_pat),
        .len_i   (ld_len),
        .msb_o   (out)
    );

    assign out_valid = out_valid_q;
    assign done      = done_q;
    assign ready     = ready_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
module tb_serial_pattern_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] pat;
    logic [3:0] len;
    logic [3:0] rep;
    logic       ready, out, out_valid, done;

    int n_vec = 0;
    int n_err = 0;
    bit exp_q[$];

    typedef struct {
        logic [7:0]  pat;
        logic [3:0]  len;
        logic [3:0]  rep;
        bit          poke;
        int          nbits;
        logic [31:0] bits;
    } vec_t;

    vec_t tbl[8];

    serial_pattern_tx #(.PW(8), .RW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pat       (pat),
        .len       (len),
        .rep       (rep),
        .ready     (ready),
        .out       (out),
        .out_valid (out_valid),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] obs();
        return {out_valid, out, done, ready};
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got {valid,out,done,ready}=%b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference stream: frames of len bits taken from pat[len-1] down to
    // pat[0], repeated rep+1 times, each optionally followed by its parity.
    function automatic void model(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r);
        int n;
        bit par;
        exp_q.delete();
        n = (l == 0 || l > 8) ? 8 : int'(l);
        for (int f = 0; f <= int'(r); f++) begin
            par = 1'b0;
            for (int k = n - 1; k >= 0; k--) begin
                exp_q.push_back(p[k]);
                par ^= p[k];
            end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            exp_q.push_back(par);
`endif
        end
    endfunction

    // Runs one transfer against exp_q; optionally re-asserts start with a
    // different pattern mid-stream, which must be ignored.
    task automatic do_xfer(input string name, input logic [7:0] p, input logic [3:0] l,
                           input logic [3:0] r, input bit poke);
        int guard = 0;
        while (!ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        check({name, "_ready"}, {3'b000, ready}, 4'b0001);
        pat = p; len = l; rep = r; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            if (poke && i == 1) begin
                start = 1'b1;
                pat   = ~p;
                len   = 4'($urandom_range(0, 15));
                rep   = 4'($urandom_range(0, 15));
            end
            if (poke && (i == 3 || i == exp_q.size() - 1)) start = 1'b0;
            check({name, "_bit"}, obs(), {1'b1, exp_q[i], 2'b00});
        end
        start = 1'b0;
        @(negedge clk);
        check({name, "_done"}, obs(), 4'b0010);
        @(negedge clk);
        check({name, "_idle"}, obs(), 4'b0001);
    endtask

    initial begin
        logic [3:0] l;
        int L;

        tbl[0] = '{8'b0000_1010, 4'd4,  4'd2, 1'b1, 12, 32'hAAA};
        tbl[1] = '{8'b1011_0001, 4'd0,  4'd0, 1'b0, 8,  32'hB1};
        tbl[2] = '{8'b0000_0001, 4'd1,  4'd3, 1'b0, 4,  32'hF};
        tbl[3] = '{8'b1011_0001, 4'd9,  4'd0, 1'b0, 8,  32'hB1};
        tbl[4] = '{8'b0000_0110, 4'd3,  4'd1, 1'b1, 6,  32'h36};
        tbl[5] = '{8'b1000_0000, 4'd8,  4'd0, 1'b0, 8,  32'h80};
        tbl[6] = '{8'b1111_1111, 4'd2,  4'd0, 1'b0, 2,  32'h3};
        tbl[7] = '{8'h5A,        4'd15, 4'd1, 1'b0, 16, 32'h5A5A};

        rst = 1'b1; start = 1'b0; pat = '0; len = '0; rep = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset", obs(), 4'b0001);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed table.
        for (int k = 0; k < 8; k++) begin
`ifdef SERIAL_PATTERN_TX_PARITY_EN
            model(tbl[k].pat, tbl[k].len, tbl[k].rep);
`else
            exp_q.delete();
            for (int i = 0; i < tbl[k].nbits; i++)
                exp_q.push_back(tbl[k].bits[tbl[k].nbits - 1 - i]);
`endif
            do_xfer($sformatf("tbl%0d", k), tbl[k].pat, tbl[k].len, tbl[k].rep, tbl[k].poke);
        end

`ifdef SERIAL_PATTERN_TX_PARITY_EN
        exp_q.delete();
        begin
            logic [9:0] pv;
            pv = 10'b1010_0_1010_0;
            for (int i = 9; i >= 0; i--) exp_q.push_back(pv[i]);
        end
        do_xfer("parity", 8'b0000_1010, 4'd4, 4'd1, 1'b0);
`endif

        // Reset on the 3rd bit of a len=4, rep=1 stream.
        @(negedge clk);
        pat = 8'b0000_1100; len = 4'd4; rep = 4'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk); check("rstmid_b1", obs(), 4'b1100);
        @(negedge clk); check("rstmid_b2", obs(), 4'b1100);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk); check("rstmid_b3", obs(), 4'b1000);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); check("rstmid_after", obs(), 4'b0001);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("rstmid_quiet", obs(), 4'b0001);
        end
        model(8'b0000_1100, 4'd4, 4'd1);
        do_xfer("rstmid_fresh", 8'b0000_1100, 4'd4, 4'd1, 1'b0);

        // rst and start together: rst wins.
        @(negedge clk);
        pat = 8'hFF; len = 4'd4; rep = 4'd0; start = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; rst = 1'b0;
        @(negedge clk); check("rst_start_a", obs(), 4'b0001);
        @(negedge clk); check("rst_start_b", obs(), 4'b0001);

        // start held high: back-to-back streams with a 2-cycle gap.
        model(8'b0000_0101, 4'd3, 4'd0);
        L = exp_q.size();
        @(negedge clk);
        pat = 8'b0000_0101; len = 4'd3; rep = 4'd0; start = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 2 * L + 4; i++) begin
            int j;
            logic [3:0] e;
            @(negedge clk);
            j = (i < L + 2) ? i : i - (L + 2);
            e = (j < L) ? {1'b1, exp_q[j], 2'b00} : 4'b0000;
            if (i == 2 * L + 2) start = 1'b0;
            check("b2b", obs() & 4'b1100, e);
        end
        @(negedge clk);
        check("b2b_stop", obs(), 4'b0001);

        // Randomized transfers against the reference model.
        for (int t = 0; t < 30; t++) begin
            logic [7:0] p;
            logic [3:0] r;
            bit pk;
            p  = 8'($urandom);
            l  = 4'($urandom_range(0, 15));
            r  = 4'($urandom_range(0, 5));
            pk = 1'($urandom_range(0, 1));
            model(p, l, r);
            do_xfer("rand", p, l, r, pk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
